// File: rtl/bus_xfer_ctrl_pkg.sv
// Shared constants, state encoding and request type for the bus transfer controller.
// Also holds the request legality rule used when a request is accepted.
package bus_xfer_ctrl_pkg;

    localparam int NREGS_DEF  = 16;
    localparam int DATA_W_DEF = 32;
    localparam int SEL_W      = 4;
    localparam int CNT_W      = 8;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_DRIVE = 3'd1;
    localparam logic [2:0] ST_WRITE = 3'd2;
    localparam logic [2:0] ST_DONE  = 3'd3;
    localparam logic [2:0] ST_ERR   = 3'd4;

    typedef struct packed {
        logic             imm;
        logic [SEL_W-1:0] src;
        logic [SEL_W-1:0] dst;
    } req_t;

    // The source index only matters on the register path; the immediate path ignores it.
    function automatic logic req_legal(input req_t r, input int nregs);
        logic [SEL_W:0] lim;
        logic           dst_ok;
        logic           src_ok;
        lim    = (SEL_W+1)'(nregs);
        dst_ok = ({1'b0, r.dst} < lim);
        src_ok = ({1'b0, r.src} < lim) && (r.src != r.dst);
        return dst_ok && (r.imm || src_ok);
    endfunction

endpackage

// File: rtl/bus_xfer_ctrl_onehot_dec.sv
// Binary-index to one-hot decoder with a global enable.
module onehot_dec #(
    parameter int N     = 16,
    parameter int SEL_W = 4
) (
    input  logic             i_en,
    input  logic [SEL_W-1:0] i_sel,
    output logic [N-1:0]     o_onehot
);

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_bit
            assign o_onehot[gi] = i_en && (i_sel == SEL_W'(gi));
        end
    endgenerate

endmodule

// File: rtl/bus_xfer_ctrl.sv
// Single-transfer bus controller: one source drives the bus for two cycles while
// the destination register is write-enabled in the second cycle.
module bus_xfer_ctrl
    import bus_xfer_ctrl_pkg::*;
#(
    parameter int NREGS  = NREGS_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clock,
    input  logic              clear,
    input  logic              start,
    input  logic              imm_sel,
    input  logic [SEL_W-1:0]  src_sel,
    input  logic [SEL_W-1:0]  dst_sel,
    input  logic [DATA_W-1:0] imm_data,
    output logic [NREGS-1:0]  reg_out,
    output logic [NREGS-1:0]  reg_in,
    output logic              temp_out,
    output logic [DATA_W-1:0] temp_data,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [CNT_W-1:0]  xfer_count
);

    logic [2:0]        r_state;
    logic [2:0]        w_state_next;
    req_t              r_req;
    req_t              w_req_in;
    logic              w_legal;
    logic [DATA_W-1:0] r_temp_data;
    logic [CNT_W-1:0]  r_count;
    logic              w_src_phase;
    logic              w_accept;

    assign w_req_in = '{imm: imm_sel, src: src_sel, dst: dst_sel};
    assign w_legal  = req_legal(w_req_in, NREGS);
    assign w_accept = (r_state == ST_IDLE) && start;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (start) w_state_next = w_legal ? ST_DRIVE : ST_ERR;
            ST_DRIVE: w_state_next = ST_WRITE;
            ST_WRITE: w_state_next = ST_DONE;
            ST_DONE:  w_state_next = ST_IDLE;
            ST_ERR:   w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            r_state     <= ST_IDLE;
            r_req       <= '0;
            r_temp_data <= '0;
            r_count     <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_req       <= w_req_in;
                r_temp_data <= imm_data;
            end
            // Count is committed as DONE is left; the 8-bit add wraps naturally.
            if (r_state == ST_DONE) begin
                r_count <= r_count + 1'b1;
            end
        end
    end

    assign w_src_phase = (r_state == ST_DRIVE) || (r_state == ST_WRITE);

    onehot_dec #(.N(NREGS), .SEL_W(SEL_W)) u_src_dec (
        .i_en     (w_src_phase && !r_req.imm),
        .i_sel    (r_req.src),
        .o_onehot (reg_out)
    );

    onehot_dec #(.N(NREGS), .SEL_W(SEL_W)) u_dst_dec (
        .i_en     (r_state == ST_WRITE),
        .i_sel    (r_req.dst),
        .o_onehot (reg_in)
    );

    assign temp_out   = w_src_phase && r_req.imm;
    assign temp_data  = r_temp_data;
    assign busy       = (r_state != ST_IDLE);
    assign done       = (r_state == ST_DONE);
    assign err        = (r_state == ST_ERR);
    assign xfer_count = r_count;

endmodule

// File: tb/tb_bus_xfer_ctrl.sv
// Randomized and directed bench for bus_xfer_ctrl against a schedule-based reference model.
module tb_bus_xfer_ctrl;

    localparam int NR = 12;
    localparam int DW = 32;

    logic          clock = 1'b0;
    logic          clear, start, imm_sel;
    logic [3:0]    src_sel, dst_sel;
    logic [DW-1:0] imm_data;
    logic [NR-1:0] reg_out, reg_in;
    logic          temp_out, busy, done, err;
    logic [DW-1:0] temp_data;
    logic [7:0]    xfer_count;

    always #5 clock = ~clock;

    bus_xfer_ctrl #(.NREGS(NR), .DATA_W(DW)) dut (
        .clock      (clock),
        .clear      (clear),
        .start      (start),
        .imm_sel    (imm_sel),
        .src_sel    (src_sel),
        .dst_sel    (dst_sel),
        .imm_data   (imm_data),
        .reg_out    (reg_out),
        .reg_in     (reg_in),
        .temp_out   (temp_out),
        .temp_data  (temp_data),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .xfer_count (xfer_count)
    );

    // Expected outputs for one cycle; an empty schedule means idle.
    typedef struct {
        logic [NR-1:0] ro;
        logic [NR-1:0] ri;
        logic          to;
        logic          dn;
        logic          er;
    } exp_t;

    exp_t          sched[$];
    int            m_cnt   = 0;
    logic [DW-1:0] m_tdata = '0;
    int            checks  = 0;
    int            failures = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        if (obs !== expv) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, expv, $time);
        end
    endtask

    task automatic step(input logic st, input logic im, input logic [3:0] s, input logic [3:0] d,
                        input logic [DW-1:0] dat, input logic clr);
        exp_t          e;
        exp_t          cur;
        logic [NR-1:0] sv;
        logic [NR-1:0] dv;
        logic          was_idle;
        start = st; imm_sel = im; src_sel = s; dst_sel = d; imm_data = dat; clear = clr;
        @(posedge clock);
        if (clr) begin
            sched.delete();
            m_cnt   = 0;
            m_tdata = '0;
        end else begin
            was_idle = (sched.size() == 0);
            if (!was_idle) begin
                e = sched.pop_front();
                if (e.dn) begin
                    m_cnt = (m_cnt + 1) % 256;
                    $display("xfer complete: count=%0d t=%0t", m_cnt, $time);
                end
                if (e.er) $display("xfer rejected: t=%0t", $time);
            end
            if (was_idle && st) begin
                m_tdata = dat;
                if ((int'(d) < NR) && (im || ((int'(s) < NR) && (s != d)))) begin
                    sv = '0;
                    dv = '0;
                    if (!im) sv[s] = 1'b1;
                    dv[d] = 1'b1;
                    sched.push_back('{ro: sv, ri: '0, to: im, dn: 1'b0, er: 1'b0});
                    sched.push_back('{ro: sv, ri: dv, to: im, dn: 1'b0, er: 1'b0});
                    sched.push_back('{ro: '0, ri: '0, to: 1'b0, dn: 1'b1, er: 1'b0});
                end else begin
                    sched.push_back('{ro: '0, ri: '0, to: 1'b0, dn: 1'b0, er: 1'b1});
                end
            end
        end
        #1;
        if (sched.size() != 0) cur = sched[0];
        else cur = '{ro: '0, ri: '0, to: 1'b0, dn: 1'b0, er: 1'b0};
        check_val("reg_out",    64'(reg_out),    64'(cur.ro));
        check_val("reg_in",     64'(reg_in),     64'(cur.ri));
        check_val("temp_out",   64'(temp_out),   64'(cur.to));
        check_val("busy",       64'(busy),       64'(sched.size() != 0));
        check_val("done",       64'(done),       64'(cur.dn));
        check_val("err",        64'(err),        64'(cur.er));
        check_val("temp_data",  64'(temp_data),  64'(m_tdata));
        check_val("xfer_count", 64'(xfer_count), 64'(m_cnt));
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, 4'd0, 4'd0, '0, 1'b0);
    endtask

    initial begin
        logic [3:0] rs, rd;
        logic       rim;
        step(1'b0, 1'b0, 4'd0, 4'd0, '0, 1'b1);
        step(1'b1, 1'b1, 4'd1, 4'd2, 32'hDEAD, 1'b1);
        // Immediate 186 into R1
        step(1'b1, 1'b1, 4'd0, 4'd1, 32'd186, 1'b0);
        idle(4);
        check_val("imm_count", 64'(xfer_count), 64'd1);
        // R1 to R2
        step(1'b1, 1'b0, 4'd1, 4'd2, 32'h55, 1'b0);
        idle(4);
        // Same source and destination
        step(1'b1, 1'b0, 4'd3, 4'd3, 32'h66, 1'b0);
        idle(2);
        check_val("err_count", 64'(xfer_count), 64'd2);
        // Restart while busy is ignored
        step(1'b1, 1'b0, 4'd1, 4'd4, 32'h77, 1'b0);
        step(1'b1, 1'b0, 4'd1, 4'd5, 32'h88, 1'b0);
        idle(4);
        // Clear during WRITE
        step(1'b1, 1'b1, 4'd0, 4'd7, 32'h99, 1'b0);
        step(1'b0, 1'b0, 4'd0, 4'd0, '0, 1'b0);
        check_val("in_write", 64'(reg_in[7]), 64'd1);
        step(1'b0, 1'b0, 4'd0, 4'd0, '0, 1'b1);
        idle(3);
        // Out-of-range indices; immediate path ignores src
        step(1'b1, 1'b0, 4'd12, 4'd2, 32'h1, 1'b0);
        idle(2);
        step(1'b1, 1'b1, 4'd0, 4'd13, 32'h2, 1'b0);
        idle(2);
        step(1'b1, 1'b1, 4'd15, 4'd3, 32'h3, 1'b0);
        idle(4);
        // Continuous start, 256 transfers from reset
        step(1'b0, 1'b0, 4'd0, 4'd0, '0, 1'b1);
        for (int k = 0; k < 1024; k++) begin
            rd = 4'($urandom_range(0, NR-1));
            step(1'b1, 1'b1, 4'($urandom_range(0, 15)), rd, $urandom, 1'b0);
        end
        check_val("count_wrap", 64'(xfer_count), 64'd0);
        idle(2);
        // Random traffic
        for (int k = 0; k < 1500; k++) begin
            rim = ($urandom_range(0, 2) == 0);
            rs  = 4'($urandom_range(0, 15));
            rd  = ($urandom_range(0, 3) == 0) ? rs : 4'($urandom_range(0, 15));
            step($urandom_range(0, 1) == 1, rim, rs, rd, $urandom, $urandom_range(0, 49) == 0);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
